cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 201 ++++++++++++++++++++
 tb/tb_cache_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with one word per line.
// Hits complete through COMPARE; misses optionally write back the victim, then refill and retry.
module cache_controller #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_rw,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              cpu_resp_hit,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t              state_q, state_d;
  logic                req_rw_q, req_rw_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                first_q, first_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic [DATA_W-1:0]   data_q [LINES];
  logic [TAG_W-1:0]    tag_q  [LINES];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    req_tag;
  logic                line_hit;
  logic                line_we;
  logic [DATA_W-1:0]   line_wdata;

  assign idx      = req_addr_q[IDX_W-1:0];
  assign req_tag  = req_addr_q[ADDR_W-1:IDX_W];
  assign line_hit = valid_q[idx] && (tag_q[idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    req_rw_d     = req_rw_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    first_d      = first_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_data_d  = resp_data_q;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_we      = 1'b0;
    line_wdata   = req_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          req_rw_d    = cpu_req_rw;
          req_addr_d  = cpu_req_addr;
          req_wdata_d = cpu_req_wdata;
          first_d     = 1'b1;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (line_hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = first_q;
          if (first_q) hit_cnt_d = hit_cnt_q + 16'd1;
          if (req_rw_q) begin
            line_we          = 1'b1;
            line_wdata       = req_wdata_q;
            dirty_d[idx]     = 1'b1;
            resp_data_d      = req_wdata_q;
          end else begin
            resp_data_d = data_q[idx];
          end
          state_d = IDLE;
        end else begin
          if (first_q) miss_cnt_d = miss_cnt_q + 16'd1;
          first_d = 1'b0;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      // Each memory phase spends its first cycle with mem_req_valid low, which
      // guarantees the idle gap between back-to-back memory requests.
      WRITEBACK: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = {tag_q[idx], idx};
          mem_wdata_d = data_q[idx];
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b0;
          mem_addr_d  = req_addr_q;
        end else if (mem_ready) begin
          line_we      = 1'b1;
          line_wdata   = mem_rdata;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          mem_valid_d  = 1'b0;
          state_d      = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_rw_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      first_q      <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_rw_q     <= req_rw_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      first_q      <= first_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Line payload carries no reset; the valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx] <= line_wdata;
      tag_q[idx]  <= req_tag;
    end
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_data  = resp_data_q;
  assign cpu_resp_hit   = resp_hit_q;
  assign mem_req_valid  = mem_valid_q;
  assign mem_req_rw     = mem_rw_q;
  assign mem_req_addr   = mem_addr_q;
  assign mem_req_wdata  = mem_wdata_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed and random checks for cache_controller against a bench-side backing memory
// and a flat reference memory of CPU-visible contents.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_rw;
  logic [15:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        cpu_resp_hit;
  logic        mem_req_valid;
  logic        mem_req_rw;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_controller #(.ADDR_W(16), .DATA_W(32), .IDX_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_rw    (cpu_req_rw),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_ready (cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data (cpu_resp_data),
    .cpu_resp_hit  (cpu_resp_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] backing [256];
  logic [31:0] exp_mem [64];

  int          mem_delay = 3;
  bit          rand_delay = 0;
  int          wb_count = 0;
  int          fill_count = 0;
  int          gap_viol = 0;
  int          stable_viol = 0;
  int          resp_count = 0;
  logic [15:0] last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  logic [15:0] last_fill_addr = '0;

  logic [31:0] rd;
  logic        hit;
  int          lat;
  bit          timed_out;
  int          f0, w0, r0, n;
  logic [15:0] h0, m0, total;
  logic [15:0] ra;
  logic        rrw;
  logic [31:0] rwd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // lat counts rising edges from the accepting edge (inclusive) until the response is visible.
  task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [31:0] wdata,
                               output logic [31:0] data, output logic hit_o, output int lat_o,
                               output bit to_o);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    lat_o = 1;
    to_o  = 1'b0;
    while (cpu_resp_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      lat_o++;
      if (lat_o > 300) begin
        to_o = 1'b1;
        break;
      end
    end
    data  = cpu_resp_data;
    hit_o = cpu_resp_hit;
  endtask

  // Memory responder: completes each request after a delay and watches handshake rules.
  initial begin
    logic        c_rw;
    logic [15:0] c_addr;
    logic [31:0] c_wdata;
    int          d;
    bit          aborted;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) begin
        c_rw    = mem_req_rw;
        c_addr  = mem_req_addr;
        c_wdata = mem_req_wdata;
        d       = rand_delay ? int'($urandom_range(1, 10)) : mem_delay;
        aborted = 1'b0;
        for (int k = 1; k < d; k++) begin
          @(negedge clk);
          if (mem_req_valid !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (mem_req_rw !== c_rw || mem_req_addr !== c_addr || (c_rw && mem_req_wdata !== c_wdata))
            stable_viol++;
        end
        if (!aborted) begin
          if (c_rw) begin
            backing[c_addr[7:0]] = c_wdata;
            wb_count++;
            last_wb_addr = c_addr;
            last_wb_data = c_wdata;
          end else begin
            mem_rdata = backing[c_addr[7:0]];
            fill_count++;
            last_fill_addr = c_addr;
          end
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
          if (mem_req_valid === 1'b1) gap_viol++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cpu_resp_valid === 1'b1) resp_count++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_rw = 1'b0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    for (int i = 0; i < 256; i++) backing[i] = 32'hA500_0000 | 32'(i);
    backing[5]  = 32'hDEAD_BEEF;
    backing[21] = 32'hCAFE_F00D;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready",      32'(cpu_req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    checkOutput("rst_resp_hit",   32'(cpu_resp_hit), 32'd0);
    checkOutput("rst_resp_data",  cpu_resp_data, 32'd0);
    checkOutput("rst_mem_valid",  32'(mem_req_valid), 32'd0);
    checkOutput("rst_mem_rw",     32'(mem_req_rw), 32'd0);
    checkOutput("rst_mem_addr",   32'(mem_req_addr), 32'd0);
    checkOutput("rst_mem_wdata",  mem_req_wdata, 32'd0);
    checkOutput("rst_hits",       32'(hit_count), 32'd0);
    checkOutput("rst_misses",     32'(miss_count), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(cpu_req_ready), 32'd1);

    // Cold read misses and fills from memory.
    f0 = fill_count; w0 = wb_count;
    applyStimulus(1'b0, 16'h0005, 32'h0, rd, hit, lat, timed_out);
    checkOutput("cold_timeout", 32'(timed_out), 32'd0);
    checkOutput("cold_data", rd, 32'hDEAD_BEEF);
    checkOutput("cold_hit", 32'(hit), 32'd0);
    checkOutput("cold_misses", 32'(miss_count), 32'd1);
    checkOutput("cold_hits", 32'(hit_count), 32'd0);
    checkOutput("cold_fills", 32'(fill_count - f0), 32'd1);
    checkOutput("cold_fill_addr", 32'(last_fill_addr), 32'h5);
    checkOutput("cold_wbs", 32'(wb_count - w0), 32'd0);

    // Repeat read hits with no memory traffic.
    f0 = fill_count; w0 = wb_count;
    applyStimulus(1'b0, 16'h0005, 32'h0, rd, hit, lat, timed_out);
    checkOutput("rehit_timeout", 32'(timed_out), 32'd0);
    checkOutput("rehit_latency", 32'(lat), 32'd2);
    checkOutput("rehit_data", rd, 32'hDEAD_BEEF);
    checkOutput("rehit_hit", 32'(hit), 32'd1);
    checkOutput("rehit_hits", 32'(hit_count), 32'd1);
    checkOutput("rehit_mem", 32'((fill_count - f0) + (wb_count - w0)), 32'd0);

    // Write hit, then read it back back-to-back.
    applyStimulus(1'b1, 16'h0005, 32'h1234_5678, rd, hit, lat, timed_out);
    checkOutput("wr_hit", 32'(hit), 32'd1);
    checkOutput("wr_latency", 32'(lat), 32'd2);
    applyStimulus(1'b0, 16'h0005, 32'h0, rd, hit, lat, timed_out);
    checkOutput("wr_read_data", rd, 32'h1234_5678);
    checkOutput("wr_read_hit", 32'(hit), 32'd1);
    checkOutput("wr_hits", 32'(hit_count), 32'd3);
    checkOutput("wr_mem", 32'((fill_count - f0) + (wb_count - w0)), 32'd0);

    // Conflict miss evicts the dirty line before refilling.
    f0 = fill_count; w0 = wb_count;
    applyStimulus(1'b0, 16'h0015, 32'h0, rd, hit, lat, timed_out);
    checkOutput("evict_timeout", 32'(timed_out), 32'd0);
    checkOutput("evict_wbs", 32'(wb_count - w0), 32'd1);
    checkOutput("evict_wb_addr", 32'(last_wb_addr), 32'h5);
    checkOutput("evict_wb_data", last_wb_data, 32'h1234_5678);
    checkOutput("evict_fills", 32'(fill_count - f0), 32'd1);
    checkOutput("evict_fill_addr", 32'(last_fill_addr), 32'h15);
    checkOutput("evict_data", rd, 32'hCAFE_F00D);
    checkOutput("evict_hit", 32'(hit), 32'd0);
    checkOutput("evict_misses", 32'(miss_count), 32'd2);
    checkOutput("evict_gap", 32'(gap_viol), 32'd0);

    // Reset during a refill drops the request and the response.
    mem_delay = 10;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 16'h0005;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(mem_req_valid === 1'b1 && mem_req_rw === 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("alloc_reached", 32'(n < 50), 32'd1);
    r0 = resp_count;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_mem_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("arst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    checkOutput("arst_misses", 32'(miss_count), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("arst_no_resp", 32'(resp_count - r0), 32'd0);
    mem_delay = 3;
    applyStimulus(1'b0, 16'h0005, 32'h0, rd, hit, lat, timed_out);
    checkOutput("post_rst_timeout", 32'(timed_out), 32'd0);
    checkOutput("post_rst_hit", 32'(hit), 32'd0);
    checkOutput("post_rst_misses", 32'(miss_count), 32'd1);
    checkOutput("post_rst_data", rd, 32'h1234_5678);

    // Random traffic over 64 words with random memory latency.
    rand_delay = 1'b1;
    for (int i = 0; i < 64; i++) exp_mem[i] = backing[i];
    h0 = hit_count;
    m0 = miss_count;
    for (int i = 0; i < 100; i++) begin
      ra  = 16'($urandom_range(0, 63));
      rrw = 1'($urandom_range(0, 1));
      rwd = $urandom;
      applyStimulus(rrw, ra, rwd, rd, hit, lat, timed_out);
      if (timed_out) checkOutput("rand_timeout", 32'(timed_out), 32'd0);
      if (rrw) exp_mem[ra[5:0]] = rwd;
      else     checkOutput("rand_read", rd, exp_mem[ra[5:0]]);
    end
    total = (hit_count - h0) + (miss_count - m0);
    checkOutput("rand_hit_plus_miss", 32'(total), 32'd100);
    checkOutput("mem_gap", 32'(gap_viol), 32'd0);
    checkOutput("mem_stable", 32'(stable_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
